// File: rtl/uart_pkg.sv
// uart_pkg: shared UART line defaults and receiver state encoding
package uart_pkg;
  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD      = 115200;
  localparam int DATA_BITS = 8;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer plus edge-detect flop, all resetting to the idle-high level
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic sync_prev
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {meta, sync, sync_prev} <= 3'b111;
    else {meta, sync, sync_prev} <= {din, meta, sync};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, done strobe and framing-error strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int BAUD     = uart_pkg::BAUD
) (
  input  logic                 clk,
  input  logic                 uart_rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);
  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_CNT - 1);
  logic                 sync, sync_prev;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           warm;
  logic                 armed;
  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (uart_rst_n),
    .din       (rxd),
    .sync      (sync),
    .sync_prev (sync_prev)
  );
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk or negedge uart_rst_n)
    if (!uart_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      warm      <= '0;
      armed     <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      warm      <= warm + 2'(warm != 2'd3);
      armed     <= armed | (&warm & sync);
      case (state)
        IDLE: if (armed && sync_prev && !sync) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF_END) begin
          cnt   <= '0;
          idx   <= '0;
          state <= sync ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == BIT_END) begin
          cnt   <= '0;
          shreg <= {sync, shreg[DATA_BITS-1:1]};
          idx   <= idx + 1'b1;
          state <= (idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == BIT_END) begin
          cnt       <= '0;
          state     <= sync ? IDLE : BREAK;
          rx_done   <= sync;
          frame_err <= !sync;
          rx_data   <= sync ? shreg : rx_data;
        end else cnt <= cnt + 1'b1;
        BREAK: state <= sync ? IDLE : BREAK;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames against a timing/queue model of the receiver
`timescale 1ns/1ps
module tb_uart_rx;
  localparam real CLK_NS = 20.0;
  localparam real BIT_NS = 434 * CLK_NS;
  logic       clk = 1'b0;
  logic       uart_rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;
  int         n_vec = 0, n_fail = 0, n_done = 0, n_err = 0;
  logic [8:0] exp_q[$];
  realtime    t0_q[$];
  logic [7:0] last_good = 8'h00;
  uart_rx dut (
    .clk        (clk),
    .uart_rst_n (uart_rst_n),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err)
  );
  always #(CLK_NS / 2) clk = ~clk;
  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $realtime);
    end
  endfunction
  always @(negedge clk) begin
    if (!uart_rst_n) begin
      check("rst_data", rx_data, 8'h00);
      check("rst_strobes", {rx_done, frame_err, rx_busy}, 3'b000);
    end else begin
      check("done_err_excl", rx_done & frame_err, 1'b0);
      if (rx_done || frame_err) begin
        if (rx_done) n_done++;
        if (frame_err) n_err++;
        if (exp_q.size() == 0) check("unexpected_strobe", {rx_done, frame_err}, 2'b00);
        else begin
          logic [8:0] e;
          realtime    t0;
          e  = exp_q.pop_front();
          t0 = t0_q.pop_front();
          check("strobe_kind", {rx_done, frame_err}, e[8] ? 2'b01 : 2'b10);
          check("strobe_time", ($realtime >= t0 + 4110 * CLK_NS) && ($realtime <= t0 + 4145 * CLK_NS), 1'b1);
          if (!e[8]) last_good = e[7:0];
        end
      end else if (t0_q.size() != 0 && $realtime > t0_q[0] + 4145 * CLK_NS) begin
        n_vec++;
        n_fail++;
        $display("FAIL strobe_timeout: no strobe for byte %0h started at %0t", exp_q[0][7:0], t0_q[0]);
        void'(exp_q.pop_front());
        void'(t0_q.pop_front());
      end
      check("rx_data_hold", rx_data, last_good);
    end
  end
  task automatic send(input logic [7:0] d, input logic stp, input real p);
    exp_q.push_back({!stp, d});
    t0_q.push_back($realtime);
    rxd = 1'b0;
    #(p);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == 4) check("busy_mid_frame", rx_busy, 1'b1);
      #(p);
    end
    rxd = stp;
    #(p);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish by %0t", $realtime);
    $fatal(1);
  end
  initial begin
    repeat (5) @(negedge clk);
    #3 uart_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("post_rst_data", rx_data, 8'h00);
    check("post_rst_busy", rx_busy, 1'b0);
    send(8'h5B, 1'b1, BIT_NS);
    #(BIT_NS);
    check("t1_data", rx_data, 8'h5B);
    check("t1_done_cnt", n_done, 1);
    check("t1_busy_low", rx_busy, 1'b0);
    rxd = 1'b0;
    #1000 check("glitch_busy_hi", rx_busy, 1'b1);
    #1000 rxd = 1'b1;
    #4000 check("glitch_busy_lo", rx_busy, 1'b0);
    check("glitch_data", rx_data, 8'h5B);
    #(2 * BIT_NS);
    send(8'hA5, 1'b0, BIT_NS);
    #(3 * BIT_NS);
    check("break_busy_hi", rx_busy, 1'b1);
    rxd = 1'b1;
    #(10 * CLK_NS) check("break_busy_lo", rx_busy, 1'b0);
    check("ferr_data_kept", rx_data, 8'h5B);
    check("ferr_cnt", n_err, 1);
    check("ferr_no_done", n_done, 1);
    #(2 * BIT_NS);
    send(8'h00, 1'b1, BIT_NS);
    send(8'hFF, 1'b1, BIT_NS);
    send(8'h55, 1'b1, BIT_NS);
    check("b2b_done_cnt", n_done, 4);
    check("b2b_data", rx_data, 8'h55);
    #(2 * BIT_NS);
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rxd = 8'hE7 >> i;
      #(BIT_NS);
    end
    rxd = 1'b0;
    #2000 uart_rst_n = 1'b0;
    exp_q.delete();
    t0_q.delete();
    last_good = 8'h00;
    #1;
    check("async_rst_data", rx_data, 8'h00);
    check("async_rst_busy", rx_busy, 1'b0);
    #999 uart_rst_n = 1'b1;
    #(BIT_NS) check("rst_low_not_start", rx_busy, 1'b0);
    rxd = 1'b1;
    #(2 * BIT_NS);
    send(8'h3C, 1'b1, BIT_NS);
    #(BIT_NS);
    check("post_abort_data", rx_data, 8'h3C);
    check("post_abort_done_cnt", n_done, 5);
    send(8'h5B, 1'b1, BIT_NS / 1.02);
    send(8'hC3, 1'b1, BIT_NS / 1.02);
    #(2 * BIT_NS);
    check("fast_data", rx_data, 8'hC3);
    send(8'h5B, 1'b1, BIT_NS / 0.98);
    send(8'hC3, 1'b1, BIT_NS / 0.98);
    #(2 * BIT_NS);
    check("slow_data", rx_data, 8'hC3);
    check("final_done_cnt", n_done, 9);
    check("final_err_cnt", n_err, 1);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
